// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses and selectable standard or
// first-word-fall-through read mode.
//
// Ports:
//   clk          - clock, all state updates on rising edge
//   rst_n        - synchronous active-low reset
//   wr_en        - write request; data_in sampled when accepted
//   data_in      - write data
//   rd_en        - read request (FWFT: pop the head word currently on data_out)
//   data_out     - read data (FWFT=0: registered on read; FWFT=1: head word while not empty)
//   full/empty   - count == DEPTH / count == 0
//   almost_full  - count >= AF_THRESH
//   almost_empty - count <= AE_THRESH
//   count        - occupancy, 0..DEPTH
//   overflow     - one-cycle pulse after a rejected write
//   underflow    - one-cycle pulse after a rejected read
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2,
    parameter bit          FWFT      = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q, almost_full_q, almost_empty_q;
    logic             overflow_q, underflow_q;
    logic             rd_acc, wr_acc;

    always_comb begin
        rd_acc = rd_en & ~empty_q;
        // A read in the same cycle frees a slot, so a write at full is still accepted.
        wr_acc = wr_en & (~full_q | rd_acc);

        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    // Flags are computed from the next count so they are registered alongside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= (count_d == CNT_W'(DEPTH));
            empty_q        <= (count_d == '0);
            almost_full_q  <= (count_d >= CNT_W'(AF_THRESH));
            almost_empty_q <= (count_d <= CNT_W'(AE_THRESH));
            overflow_q     <= wr_en & ~wr_acc;
            underflow_q    <= rd_en & empty_q;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented combinationally; forced to zero while empty to avoid
            // exposing stale or uninitialised storage.
            assign data_out = empty_q ? '0 : mem[rd_ptr_q];
        end else begin : g_std
            logic [DATA_W-1:0] data_out_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_out_q <= '0;
                end else if (rd_acc) begin
                    data_out_q <= mem[rd_ptr_q];
                end
            end

            assign data_out = data_out_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three configurations (DEPTH=16 standard, DEPTH=5 standard,
// DEPTH=16 FWFT) driven through a shared stimulus bus, checked against a queue-based model.
module tb_sync_fifo_param;

    typedef logic [13:0] stat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    int         sel = 0;

    logic [7:0] d0, d1, d2;
    logic [4:0] c0, c2;
    logic [2:0] c1;
    logic       f0, e0, af0, ae0, ov0, un0;
    logic       f1, e1, af1, ae1, ov1, un1;
    logic       f2, e2, af2, ae2, ov2, un2;

    stat_t      o_stat;
    logic [7:0] o_dout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    int         m_depth, m_af, m_ae;
    bit         m_fwft;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0)) u_std16 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en && sel == 0), .data_in(data_in),
        .rd_en(rd_en && sel == 0), .data_out(d0), .full(f0), .empty(e0), .almost_full(af0),
        .almost_empty(ae0), .count(c0), .overflow(ov0), .underflow(un0)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1'b0)) u_std5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en && sel == 1), .data_in(data_in),
        .rd_en(rd_en && sel == 1), .data_out(d1), .full(f1), .empty(e1), .almost_full(af1),
        .almost_empty(ae1), .count(c1), .overflow(ov1), .underflow(un1)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en && sel == 2), .data_in(data_in),
        .rd_en(rd_en && sel == 2), .data_out(d2), .full(f2), .empty(e2), .almost_full(af2),
        .almost_empty(ae2), .count(c2), .overflow(ov2), .underflow(un2)
    );

    function automatic stat_t pack(int c, bit f, bit e, bit af, bit ae, bit ov, bit un);
        return {8'(c), f, e, af, ae, ov, un};
    endfunction

    always_comb begin
        o_stat = '0;
        o_dout = '0;
        case (sel)
            1: begin o_stat = pack(int'(c1), f1, e1, af1, ae1, ov1, un1); o_dout = d1; end
            2: begin o_stat = pack(int'(c2), f2, e2, af2, ae2, ov2, un2); o_dout = d2; end
            default: begin o_stat = pack(int'(c0), f0, e0, af0, ae0, ov0, un0); o_dout = d0; end
        endcase
    end

    task automatic use_cfg(input int s);
        sel = s;
        case (s)
            1: begin m_depth = 5;  m_af = 4;  m_ae = 1; m_fwft = 1'b0; end
            2: begin m_depth = 16; m_af = 14; m_ae = 2; m_fwft = 1'b1; end
            default: begin m_depth = 16; m_af = 14; m_ae = 2; m_fwft = 1'b0; end
        endcase
    endtask

    // One clock of stimulus; returns the model's expectation for the cycle after the edge.
    task automatic step(input bit w, input bit r, input logic [7:0] d,
                        output stat_t es, output logic [7:0] ed, output bit dchk);
        bit         emp, ful, racc, wacc, ov, un;
        logic [7:0] head;
        int         n;
        emp  = (mq.size() == 0);
        ful  = (mq.size() == m_depth);
        racc = r && !emp;
        wacc = w && (!ful || racc);
        ov   = w && !wacc;
        un   = r && emp;
        if (racc) begin
            head = mq.pop_front();
            if (!m_fwft) m_dout = head;
        end
        if (wacc) mq.push_back(d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        n    = mq.size();
        es   = pack(n, n == m_depth, n == 0, n >= m_af, n <= m_ae, ov, un);
        dchk = !m_fwft || n != 0;
        ed   = m_fwft ? ((n != 0) ? mq[0] : 8'h00) : m_dout;
    endtask

    task automatic test_reset(input int s);
        use_cfg(s);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        m_dout = 8'h00;
        checks++;
        if (o_stat !== pack(0, 0, 1, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL reset[cfg%0d] status: got %h want %h", s, o_stat,
                     pack(0, 0, 1, 0, 1, 0, 0));
        end
        if (!m_fwft) begin
            checks++;
            if (o_dout !== 8'h00) begin
                errors++;
                $display("FAIL reset[cfg%0d] data_out: got %h want 00", s, o_dout);
            end
        end
    endtask

    task automatic test_fill;
        stat_t es; logic [7:0] ed; bit dc;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 8'(i), es, ed, dc);
            checks++;
            if (o_stat !== es) begin
                errors++;
                $display("FAIL fill[%0d] status: got %h want %h", i, o_stat, es);
            end
        end
        checks++;
        if ({f0, af0, c0} !== {1'b1, 1'b1, 5'd16}) begin
            errors++;
            $display("FAIL fill_final full/af/count: got %b%b/%0d want 1/1/16", f0, af0, c0);
        end
    endtask

    task automatic test_overflow;
        stat_t es; logic [7:0] ed; bit dc;
        step(1'b1, 1'b0, 8'hFF, es, ed, dc);
        checks++;
        if (o_stat !== es) begin
            errors++;
            $display("FAIL overflow_pulse status: got %h want %h", o_stat, es);
        end
        step(1'b0, 1'b0, 8'h00, es, ed, dc);
        checks++;
        if (o_stat !== es) begin
            errors++;
            $display("FAIL overflow_clear status: got %h want %h", o_stat, es);
        end
    endtask

    task automatic test_read;
        stat_t es; logic [7:0] ed; bit dc;
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'h00, es, ed, dc);
            checks++;
            if (o_stat !== es || o_dout !== ed) begin
                errors++;
                $display("FAIL read[%0d]: got %h/%h want %h/%h", i, o_stat, o_dout, es, ed);
            end
        end
        step(1'b0, 1'b1, 8'h00, es, ed, dc);
        checks++;
        if (o_stat !== es || o_dout !== 8'd16) begin
            errors++;
            $display("FAIL underflow_empty: got %h/%h want %h/10", o_stat, o_dout, es);
        end
    endtask

    task automatic test_back_to_back;
        stat_t es; logic [7:0] ed; bit dc;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h40 + i), es, ed, dc);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'(8'h80 + i), es, ed, dc);
            checks++;
            if (o_stat !== es || o_dout !== ed) begin
                errors++;
                $display("FAIL b2b_full[%0d]: got %h/%h want %h/%h", i, o_stat, o_dout, es, ed);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00, es, ed, dc);
            checks++;
            if (o_stat !== es || o_dout !== ed) begin
                errors++;
                $display("FAIL b2b_drain[%0d]: got %h/%h want %h/%h", i, o_stat, o_dout, es, ed);
            end
        end
        step(1'b1, 1'b1, 8'h77, es, ed, dc);
        checks++;
        if (o_stat !== es || c0 !== 5'd1 || un0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_empty: got %h want %h (count=1, underflow=1)", o_stat, es);
        end
        step(1'b0, 1'b1, 8'h00, es, ed, dc);
        checks++;
        if (o_dout !== 8'h77 || o_stat !== es) begin
            errors++;
            $display("FAIL b2b_empty_word: got %h/%h want %h/77", o_stat, o_dout, es);
        end
    endtask

    task automatic test_wrap;
        stat_t es; logic [7:0] ed; bit dc;
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 6; i++) begin
                step(1'b1, 1'b0, 8'($urandom), es, ed, dc);
                checks++;
                if (o_stat !== es) begin
                    errors++;
                    $display("FAIL wrap_fill[%0d.%0d]: got %h want %h", round, i, o_stat, es);
                end
            end
            for (int i = 0; i < 6; i++) begin
                step(1'b0, 1'b1, 8'h00, es, ed, dc);
                checks++;
                if (o_stat !== es || o_dout !== ed) begin
                    errors++;
                    $display("FAIL wrap_drain[%0d.%0d]: got %h/%h want %h/%h", round, i,
                             o_stat, o_dout, es, ed);
                end
            end
        end
    endtask

    task automatic test_fwft;
        stat_t es; logic [7:0] ed; bit dc;
        step(1'b1, 1'b0, 8'hA5, es, ed, dc);
        checks++;
        if (o_stat !== es || o_dout !== 8'hA5) begin
            errors++;
            $display("FAIL fwft_show: got %h/%h want %h/a5", o_stat, o_dout, es);
        end
        step(1'b0, 1'b1, 8'h00, es, ed, dc);
        checks++;
        if (o_stat !== es || e2 !== 1'b1) begin
            errors++;
            $display("FAIL fwft_pop: got %h want %h", o_stat, es);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 8'(8'hC0 + i), es, ed, dc);
            checks++;
            if (o_stat !== es || (dc && o_dout !== ed)) begin
                errors++;
                $display("FAIL fwft_burst[%0d]: got %h/%h want %h/%h", i, o_stat, o_dout, es, ed);
            end
        end
        // Reset mid-burst with traffic still requested; reset must win.
        wr_en = 1'b1;
        rd_en = 1'b1;
        data_in = 8'hEE;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        mq.delete();
        checks++;
        if (o_stat !== pack(0, 0, 1, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL fwft_midreset: got %h want %h", o_stat, pack(0, 0, 1, 0, 1, 0, 0));
        end
    endtask

    task automatic test_random(input int s);
        stat_t es; logic [7:0] ed; bit dc, w, r;
        int    pw;
        for (int i = 0; i < 300; i++) begin
            pw = ((i / 50) % 2 == 0) ? 70 : 30;
            w  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < 100 - pw);
            step(w, r, 8'($urandom), es, ed, dc);
            checks++;
            if (o_stat !== es || (dc && o_dout !== ed)) begin
                errors++;
                $display("FAIL random[cfg%0d,%0d]: got %h/%h want %h/%h", s, i, o_stat, o_dout,
                         es, ed);
            end
        end
    endtask

    initial begin
        test_reset(0);
        test_fill();
        test_overflow();
        test_read();
        test_reset(0);
        test_back_to_back();
        test_reset(1);
        test_wrap();
        test_reset(2);
        test_fwft();
        for (int s = 0; s < 3; s++) begin
            test_reset(s);
            test_random(s);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
